// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the CPU fetch (I) and data (D) channels.
// Define ARB_PERF_CNT_EN to build the grant/conflict performance counters.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    input  logic              i_rready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wen,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [STRB_W-1:0] d_wstrb,
    input  logic              d_ren,
    output logic              d_req_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    input  logic              d_rready,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wen,
    output logic [DATA_W-1:0] m_wdata,
    output logic [STRB_W-1:0] m_wstrb,
    output logic              m_ren,
    input  logic              m_req_ready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [31:0]       cnt_i_grant,
    output logic [31:0]       cnt_d_grant,
    output logic [31:0]       cnt_conflict
);
    typedef enum logic [2:0] {IDLE = 3'b001, REQ = 3'b010, RESP = 3'b100} state_t;
    state_t state, state_nx;
    logic              own_d, op_wr;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [STRB_W-1:0] cap_wstrb;
    logic              in_idle, in_req, in_resp;
    logic              i_pend, d_pend, d_win, gnt_i, gnt_d, own_rready;

    assign in_idle    = state == IDLE;
    assign in_req     = state == REQ;
    assign in_resp    = state == RESP;
    assign i_pend     = i_req_valid;
    assign d_pend     = d_wen | d_ren;
    // own_d doubles as last_grant: it is rewritten on every grant and reset to I
    assign d_win      = d_pend & (~i_pend | (FIXED_PRIO != 0) | ~own_d);
    // grants are gated by rst so the ready outputs read 0 while reset is held
    assign gnt_d      = rst & in_idle & d_win;
    assign gnt_i      = rst & in_idle & i_pend & ~d_win;
    assign own_rready = own_d ? d_rready : i_rready;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    always_comb begin
        state_nx = in_idle ? ((gnt_i | gnt_d) ? REQ : IDLE)
                 : in_req  ? (m_req_ready ? (op_wr ? IDLE : RESP) : REQ)
                 : in_resp ? ((m_rvalid & own_rready) ? IDLE : RESP)
                 : IDLE;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            own_d     <= 1'b0;
            op_wr     <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
        end else if (gnt_i | gnt_d) begin
            own_d     <= gnt_d;
            op_wr     <= gnt_d & d_wen;
            cap_addr  <= gnt_d ? d_addr : i_addr;
            cap_wdata <= gnt_d ? d_wdata : '0;
            cap_wstrb <= gnt_d ? d_wstrb : '0;
        end

    always_comb begin
        i_req_ready = gnt_i;
        d_req_ready = gnt_d;
        m_wen       = in_req & op_wr;
        m_ren       = in_req & ~op_wr;
        m_addr      = cap_addr;
        m_wdata     = cap_wdata;
        m_wstrb     = cap_wstrb;
        m_rready    = in_resp & own_rready;
        i_rvalid    = in_resp & ~own_d & m_rvalid;
        d_rvalid    = in_resp & own_d & m_rvalid;
        i_rdata     = (in_resp & ~own_d) ? m_rdata : '0;
        d_rdata     = (in_resp & own_d) ? m_rdata : '0;
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] cnt_i, cnt_d, cnt_c;
    logic        conflict;

    assign conflict = in_idle ? (i_pend & d_pend) : (own_d ? i_pend : d_pend);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt_i <= '0;
            cnt_d <= '0;
            cnt_c <= '0;
        end else begin
            cnt_i <= cnt_i + 32'(gnt_i);
            cnt_d <= cnt_d + 32'(gnt_d);
            cnt_c <= cnt_c + 32'(conflict);
        end

    assign cnt_i_grant  = cnt_i;
    assign cnt_d_grant  = cnt_d;
    assign cnt_conflict = cnt_c;
`else
    assign cnt_i_grant  = 32'h0;
    assign cnt_d_grant  = 32'h0;
    assign cnt_conflict = 32'h0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a transaction-level model.
// Instance 0 is round-robin, instance 1 is fixed data-priority; both share the same stimulus.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_wstrb;
    logic        i_req_valid, i_rready, d_wen, d_ren, d_rready, m_req_ready, m_rvalid;

    logic [1:0]       i_req_ready_a, i_rvalid_a, d_req_ready_a, d_rvalid_a, m_wen_a, m_ren_a, m_rready_a;
    logic [1:0][31:0] i_rdata_a, d_rdata_a, m_addr_a, m_wdata_a, cnt_i_a, cnt_d_a, cnt_c_a;
    logic [1:0][3:0]  m_wstrb_a;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(g)) dut (
            .clk(clk), .rst(rst),
            .i_addr(i_addr), .i_req_valid(i_req_valid), .i_req_ready(i_req_ready_a[g]),
            .i_rdata(i_rdata_a[g]), .i_rvalid(i_rvalid_a[g]), .i_rready(i_rready),
            .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_ren(d_ren),
            .d_req_ready(d_req_ready_a[g]), .d_rdata(d_rdata_a[g]), .d_rvalid(d_rvalid_a[g]),
            .d_rready(d_rready),
            .m_addr(m_addr_a[g]), .m_wen(m_wen_a[g]), .m_wdata(m_wdata_a[g]), .m_wstrb(m_wstrb_a[g]),
            .m_ren(m_ren_a[g]), .m_req_ready(m_req_ready), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
            .m_rready(m_rready_a[g]),
            .cnt_i_grant(cnt_i_a[g]), .cnt_d_grant(cnt_d_a[g]), .cnt_conflict(cnt_c_a[g])
        );
    end

    int          n_vec = 0, n_err = 0, sel = 0;
    bit          prio, busy, in_resp, own_d, wr, last_d;
    logic [31:0] ex_addr, ex_wdata, c_i, c_d, c_c;
    logic [3:0]  ex_strb, seq;
    bit          gq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0; d_wstrb = 0;
        i_req_valid = 0; i_rready = 0; d_wen = 0; d_ren = 0; d_rready = 0;
        m_req_ready = 0; m_rvalid = 0;
    endtask

    task automatic do_reset(input int s);
        rst = 0;
        i_req_valid = 1; d_wen = 1; m_rvalid = 1; m_rdata = 32'h1234_5678;
        #1;
        chk("rst.i_req_ready", 32'(i_req_ready_a[s]), 0);
        chk("rst.d_req_ready", 32'(d_req_ready_a[s]), 0);
        chk("rst.m_wen", 32'(m_wen_a[s]), 0);
        chk("rst.m_ren", 32'(m_ren_a[s]), 0);
        chk("rst.m_rready", 32'(m_rready_a[s]), 0);
        chk("rst.i_rvalid", 32'(i_rvalid_a[s]), 0);
        chk("rst.d_rvalid", 32'(d_rvalid_a[s]), 0);
        chk("rst.m_addr", m_addr_a[s], 0);
        chk("rst.m_wdata", m_wdata_a[s], 0);
        chk("rst.m_wstrb", 32'(m_wstrb_a[s]), 0);
        chk("rst.i_rdata", i_rdata_a[s], 0);
        chk("rst.d_rdata", d_rdata_a[s], 0);
        chk("rst.cnt_i", cnt_i_a[s], 0);
        chk("rst.cnt_d", cnt_d_a[s], 0);
        chk("rst.cnt_c", cnt_c_a[s], 0);
        clear_inputs();
        busy = 0; in_resp = 0; own_d = 0; last_d = 0; wr = 0;
        c_i = 0; c_d = 0; c_c = 0; gq.delete();
        sel = s; prio = (s == 1);
        @(negedge clk);
        rst = 1;
    endtask

    // One clock of the model: check the DUT against the current transaction view, then advance.
    task automatic step(input string tag);
        bit di, dd, wd, req, rsp, rr;
        #1;
        di  = i_req_valid;
        dd  = d_wen || d_ren;
        req = busy && !in_resp;
        rsp = busy && in_resp;
        wd  = dd && (!di || prio || !last_d);
        rr  = rsp && (own_d ? d_rready : i_rready);
        chk({tag, ".i_req_ready"}, 32'(i_req_ready_a[sel]), 32'(!busy && di && !wd));
        chk({tag, ".d_req_ready"}, 32'(d_req_ready_a[sel]), 32'(!busy && wd));
        chk({tag, ".m_wen"}, 32'(m_wen_a[sel]), 32'(req && wr));
        chk({tag, ".m_ren"}, 32'(m_ren_a[sel]), 32'(req && !wr));
        chk({tag, ".m_rready"}, 32'(m_rready_a[sel]), 32'(rr));
        chk({tag, ".i_rvalid"}, 32'(i_rvalid_a[sel]), 32'(rsp && !own_d && m_rvalid));
        chk({tag, ".d_rvalid"}, 32'(d_rvalid_a[sel]), 32'(rsp && own_d && m_rvalid));
        if (req) begin
            chk({tag, ".m_addr"}, m_addr_a[sel], ex_addr);
            if (wr) begin
                chk({tag, ".m_wdata"}, m_wdata_a[sel], ex_wdata);
                chk({tag, ".m_wstrb"}, 32'(m_wstrb_a[sel]), 32'(ex_strb));
            end
        end
        if (rsp && m_rvalid)
            chk({tag, ".rdata"}, own_d ? d_rdata_a[sel] : i_rdata_a[sel], m_rdata);
`ifdef ARB_PERF_CNT_EN
        chk({tag, ".cnt_i"}, cnt_i_a[sel], c_i);
        chk({tag, ".cnt_d"}, cnt_d_a[sel], c_d);
        chk({tag, ".cnt_c"}, cnt_c_a[sel], c_c);
`else
        chk({tag, ".cnt_i"}, cnt_i_a[sel], 0);
        chk({tag, ".cnt_d"}, cnt_d_a[sel], 0);
        chk({tag, ".cnt_c"}, cnt_c_a[sel], 0);
`endif
        if (i_req_ready_a[sel] || d_req_ready_a[sel]) gq.push_back(d_req_ready_a[sel]);
        if (busy && (own_d ? di : dd)) c_c++;
        if (!busy && (di || dd)) begin
            if (di && dd) c_c++;
            busy = 1; in_resp = 0; own_d = wd; last_d = wd; wr = wd && d_wen;
            ex_addr = wd ? d_addr : i_addr; ex_wdata = d_wdata; ex_strb = d_wstrb;
            if (wd) c_d++; else c_i++;
        end else if (req && m_req_ready) begin
            if (wr) busy = 0; else in_resp = 1;
        end else if (rr && m_rvalid) busy = 0;
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        do_reset(0);
        // single fetch
        i_req_valid = 1; i_addr = 32'h100;
        step("t1.grant");
        chk("t1.m_ren", 32'(m_ren_a[0]), 1);
        chk("t1.m_addr", m_addr_a[0], 32'h100);
        i_req_valid = 0; m_req_ready = 1;
        step("t1.req");
        m_req_ready = 0; m_rvalid = 1; m_rdata = 32'h2402_0005; i_rready = 1;
        #1;
        chk("t1.i_rvalid", 32'(i_rvalid_a[0]), 1);
        chk("t1.i_rdata", i_rdata_a[0], 32'h2402_0005);
        chk("t1.d_rvalid", 32'(d_rvalid_a[0]), 0);
        step("t1.resp");
        m_rvalid = 0;
        // store held across memory stalls
        d_wen = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b1100;
        step("t2.grant");
        d_wen = 0; d_wdata = 0; d_wstrb = 0;
        for (int k = 0; k < 3; k++) begin
            chk("t2.m_wen", 32'(m_wen_a[0]), 1);
            chk("t2.m_addr", m_addr_a[0], 32'h40);
            chk("t2.m_wdata", m_wdata_a[0], 32'hDEAD_BEEF);
            chk("t2.m_wstrb", 32'(m_wstrb_a[0]), 32'hC);
            chk("t2.m_rready", 32'(m_rready_a[0]), 0);
            step("t2.stall");
        end
        m_req_ready = 1;
        step("t2.accept");
        m_req_ready = 0;
        // response backpressure
        d_ren = 1; d_addr = 32'h80;
        step("t5.grant");
        d_ren = 0; m_req_ready = 1;
        step("t5.req");
        m_req_ready = 0; m_rvalid = 1; m_rdata = 32'hCAFE_0001; d_rready = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t5.m_rready_low", 32'(m_rready_a[0]), 0);
            chk("t5.d_rvalid", 32'(d_rvalid_a[0]), 1);
            step("t5.hold");
        end
        d_rready = 1;
        #1;
        chk("t5.m_rready_high", 32'(m_rready_a[0]), 1);
        step("t5.done");
        m_rvalid = 0; i_req_valid = 1; i_addr = 32'h204;
        #1;
        chk("t5.idle_again", 32'(i_req_ready_a[0]), 1);
        step("t5.next");
        i_req_valid = 0;
        // reset in the middle of a request
        @(posedge clk);
        #2;
        chk("t6.mid_req", 32'(m_ren_a[0]), 1);
        do_reset(0);
        i_req_valid = 1; d_ren = 1;
        step("t6.tie");
        chk("t6.d_first", 32'(gq.size() == 1 && gq[0]), 1);
        // round-robin ties
        do_reset(0);
        i_req_valid = 1; d_ren = 1; m_req_ready = 1; m_rvalid = 1; i_rready = 1; d_rready = 1;
        repeat (12) step("t3");
        seq = gq.size() >= 4 ? {gq[0], gq[1], gq[2], gq[3]} : 4'bxxxx;
        chk("t3.order", 32'(seq), 32'b1010);
`ifdef ARB_PERF_CNT_EN
        chk("t3.cnt_d", cnt_d_a[0], 2);
        chk("t3.cnt_i", cnt_i_a[0], 2);
`endif
        // fixed priority: D load while I waits
        do_reset(1);
        i_req_valid = 1; d_ren = 1; i_addr = 32'h300; d_addr = 32'h400;
        step("t4.tie");
        d_ren = 0; m_req_ready = 1;
        step("t4.req");
        m_req_ready = 0; m_rvalid = 1; d_rready = 1; m_rdata = 32'h0BAD_F00D;
        step("t4.resp");
        m_rvalid = 0;
        #1;
        chk("t4.i_next", 32'(i_req_ready_a[1]), 1);
        step("t4.i_grant");
        seq = gq.size() == 2 ? {2'b00, gq[0], gq[1]} : 4'bxxxx;
        chk("t4.order", 32'(seq), 32'b0010);
        do_reset(1);
        i_req_valid = 1; d_ren = 1; m_req_ready = 1; m_rvalid = 1; i_rready = 1; d_rready = 1;
        repeat (6) step("t4.fixed");
        seq = gq.size() == 2 ? {2'b00, gq[0], gq[1]} : 4'bxxxx;
        chk("t4.d_twice", 32'(seq), 32'b0011);
        // random traffic on both arbitration modes
        for (int s = 0; s < 2; s++) begin
            do_reset(s);
            repeat (1500) begin
                i_req_valid = 1'($urandom_range(0, 1));
                d_wen       = ($urandom % 4) == 0;
                d_ren       = ($urandom % 3) == 0;
                i_addr      = $urandom;
                d_addr      = $urandom & 32'hFFFF_FFFC;
                d_wdata     = $urandom;
                d_wstrb     = 4'($urandom);
                m_req_ready = 1'($urandom_range(0, 1));
                m_rvalid    = 1'($urandom_range(0, 1));
                m_rdata     = $urandom;
                i_rready    = ($urandom % 4) != 0;
                d_rready    = ($urandom % 4) != 0;
                step("rand");
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
